// File: rtl/bus_arbiter.sv
// Three-master round-robin bus arbiter. Holds the grant for a whole cyc
// burst and turns decoder faults and slave stalls into a one-cycle err.
module bus_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  m_cyc_i,
  input  logic [2:0]  m_stb_i,
  input  logic [2:0]  m_we_i,
  input  logic [95:0] m_adr_i,
  input  logic [95:0] m_dat_i,
  input  logic [11:0] m_sel_i,
  output logic [2:0]  m_ack_o,
  output logic [2:0]  m_err_o,
  output logic [31:0] m_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_fault_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  localparam logic [1:0]    NO_OWNER = 2'd3;
  localparam logic [TW-1:0] CNT_MAX  = TW'(TIMEOUT - 1);

  state_t        state;
  logic [1:0]    grant;
  logic [1:0]    ptr;
  logic [TW-1:0] cnt;

  logic          own_cyc, own_stb, own_we;
  logic [31:0]   own_adr, own_dat;
  logic [3:0]    own_sel;
  logic [2:0]    own_oh;
  logic [1:0]    pick;
  logic [1:0]    ptr_after;

  // Select the current owner's request signals; no owner yields all zeros.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_oh  = '0;
    ptr_after = 2'd0;
    case (grant)
      2'd0: begin
        own_cyc = m_cyc_i[0]; own_stb = m_stb_i[0]; own_we = m_we_i[0];
        own_adr = m_adr_i[31:0]; own_dat = m_dat_i[31:0]; own_sel = m_sel_i[3:0];
        own_oh  = 3'b001; ptr_after = 2'd1;
      end
      2'd1: begin
        own_cyc = m_cyc_i[1]; own_stb = m_stb_i[1]; own_we = m_we_i[1];
        own_adr = m_adr_i[63:32]; own_dat = m_dat_i[63:32]; own_sel = m_sel_i[7:4];
        own_oh  = 3'b010; ptr_after = 2'd2;
      end
      2'd2: begin
        own_cyc = m_cyc_i[2]; own_stb = m_stb_i[2]; own_we = m_we_i[2];
        own_adr = m_adr_i[95:64]; own_dat = m_dat_i[95:64]; own_sel = m_sel_i[11:8];
        own_oh  = 3'b100; ptr_after = 2'd0;
      end
      default: ;
    endcase
  end

  // Round-robin pick: first requesting master at or after the pointer, mod 3.
  always_comb begin
    pick = 2'd0;
    case (ptr)
      2'd1:    pick = m_cyc_i[1] ? 2'd1 : (m_cyc_i[2] ? 2'd2 : 2'd0);
      2'd2:    pick = m_cyc_i[2] ? 2'd2 : (m_cyc_i[0] ? 2'd0 : 2'd1);
      default: pick = m_cyc_i[0] ? 2'd0 : (m_cyc_i[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Slave-side and master-side outputs; strobe is suppressed while in ERR.
  always_comb begin
    s_cyc_o = (state != IDLE) && own_cyc;
    s_stb_o = (state == BUSY) && own_stb;
    s_we_o  = own_we;
    s_adr_o = own_adr;
    s_dat_o = own_dat;
    s_sel_o = own_sel;
    m_dat_o = s_dat_i;
    m_ack_o = ((state == BUSY) && s_ack_i) ? own_oh : '0;
    m_err_o = ((state == ERR) && own_cyc) ? own_oh : '0;
    grant_o = grant;
  end

  // Arbitration FSM with stall timeout; ack always takes precedence over
  // fault or timeout in the same cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      grant <= NO_OWNER;
      ptr   <= 2'd0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (|m_cyc_i) begin
            grant <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!own_cyc) begin
            state <= IDLE;
            grant <= NO_OWNER;
            ptr   <= ptr_after;
            cnt   <= '0;
          end else if (s_ack_i || !s_stb_o) begin
            cnt <= '0;
          end else if (s_fault_i || cnt == CNT_MAX) begin
            state <= ERR;
            cnt   <= '0;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        ERR: begin
          cnt <= '0;
          if (own_cyc) begin
            state <= BUSY;
          end else begin
            state <= IDLE;
            grant <= NO_OWNER;
            ptr   <= ptr_after;
          end
        end
        default: begin
          state <= IDLE;
          grant <= NO_OWNER;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
